// File: rtl/mor1kx_spr_bus_master_pkg.sv
// Shared SPR bus master definitions: request op codes (also used by the debug
// unit) and the read-modify-write data helper.
package mor1kx_spr_bus_master_pkg;

    localparam logic [1:0] OR1K_SPRM_OP_READ  = 2'd0;
    localparam logic [1:0] OR1K_SPRM_OP_WRITE = 2'd1;
    localparam logic [1:0] OR1K_SPRM_OP_SET   = 2'd2;
    localparam logic [1:0] OR1K_SPRM_OP_CLR   = 2'd3;

    // Value written back in the WR phase of a set/clear-bits access
    function automatic logic [31:0] rmw_data(input logic [1:0]  op,
                                             input logic [31:0] old,
                                             input logic [31:0] mask);
        logic [31:0] res;
        res = old;
        if (op == OR1K_SPRM_OP_SET)
            res = old | mask;
        else if (op == OR1K_SPRM_OP_CLR)
            res = old & ~mask;
        return res;
    endfunction

endpackage

// File: rtl/mor1kx_spr_bus_master.sv
// SPR bus initiator: turns debug/host requests into READ, WRITE or atomic
// set/clear-bits accesses on the shared SPR bus, with an ack timeout so an
// unmapped address cannot hang the requester.
module mor1kx_spr_bus_master
    import mor1kx_spr_bus_master_pkg::*;
#(
    parameter int OPTION_SPR_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    input  logic        cpu_spr_busy_i,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i
);

    localparam int CNT_W = $clog2(OPTION_SPR_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] mask_q, mask_d;
    logic        access_q, access_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;   // doubles as the RMW old-value register
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic        timeout;

    // Only accept while idle and the CPU is not using the bus; never during reset
    assign req_ready_o = (state_q == ST_IDLE) && !cpu_spr_busy_i && !rst;

    assign cnt_nxt = cnt_q + 1'b1;
    assign timeout = (cnt_nxt == CNT_W'(OPTION_SPR_TIMEOUT));

    // Next-state and registered-output logic for the request/bus/response FSM
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mask_d      = mask_q;
        access_d    = access_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    op_d      = req_op_i;
                    mask_d    = req_dat_i;
                    addr_d    = req_addr_i;
                    access_d  = 1'b1;
                    cnt_d     = '0;
                    rsp_dat_d = '0;
                    if (req_op_i == OR1K_SPRM_OP_WRITE) begin
                        state_d = ST_WR;
                        we_d    = 1'b1;
                        wdat_d  = req_dat_i;
                    end else begin
                        state_d = ST_RD;
                        we_d    = 1'b0;
                        wdat_d  = '0;
                    end
                end
            end
            ST_RD: begin
                // An ack always beats a timeout landing in the same cycle
                if (spr_bus_ack_i) begin
                    rsp_dat_d = spr_dat_i;
                    if (op_q == OR1K_SPRM_OP_READ) begin
                        state_d     = ST_RESP;
                        access_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        // Back-to-back write: strobe and address held, only we rises
                        state_d = ST_WR;
                        we_d    = 1'b1;
                        wdat_d  = rmw_data(op_q, spr_dat_i, mask_q);
                        cnt_d   = '0;
                    end
                end else if (timeout) begin
                    state_d     = ST_RESP;
                    access_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            ST_WR: begin
                if (spr_bus_ack_i) begin
                    state_d     = ST_RESP;
                    access_d    = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                end else if (timeout) begin
                    state_d     = ST_RESP;
                    access_d    = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access without a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OR1K_SPRM_OP_READ;
            mask_q      <= '0;
            access_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            access_q    <= access_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign spr_access_o = access_q;
    assign spr_we_o     = we_q;
    assign spr_addr_o   = addr_q;
    assign spr_dat_o    = wdat_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_dat_o    = rsp_dat_q;

endmodule

// File: tb/tb_mor1kx_spr_bus_master.sv
// Bench for mor1kx_spr_bus_master: PIC-like responder (PICMR/PICSR, one
// unmapped address) with programmable ack delay, directed scenarios and a
// randomized run checked against a transaction-level model.
module tb_mor1kx_spr_bus_master;

    localparam logic [15:0] PICMR = 16'h4800;
    localparam logic [15:0] PICSR = 16'h4802;
    localparam logic [15:0] UNMAP = 16'h7FFF;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o;
    logic [1:0]  req_op_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_dat_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        cpu_spr_busy_i;
    logic        spr_access_o, spr_we_o, spr_bus_ack_i;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_dat_o, spr_dat_i;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mor1kx_spr_bus_master #(.OPTION_SPR_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .cpu_spr_busy_i(cpu_spr_busy_i),
        .spr_access_o(spr_access_o), .spr_we_o(spr_we_o),
        .spr_addr_o(spr_addr_o), .spr_dat_o(spr_dat_o),
        .spr_bus_ack_i(spr_bus_ack_i), .spr_dat_i(spr_dat_i)
    );

    // ---------------- responder ----------------
    logic [31:0] picmr = 32'h0;
    logic [31:0] picsr = 32'h0;
    int          wait_cnt;
    int          ack_dly = 0;
    logic        mapped;

    assign mapped        = (spr_addr_o == PICMR) || (spr_addr_o == PICSR);
    assign spr_bus_ack_i = spr_access_o && mapped && (wait_cnt >= ack_dly);
    assign spr_dat_i     = !spr_bus_ack_i ? 32'h0 : (spr_addr_o == PICMR) ? picmr : picsr;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (spr_access_o && !spr_bus_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (!rst && spr_access_o && spr_we_o && spr_bus_ack_i) begin
            if (spr_addr_o == PICMR) picmr <= spr_dat_o;
            else picsr <= spr_dat_o;
        end
    end

    // ---------------- bus monitor ----------------
    int          acc_total = 0, wr_total = 0, starts = 0;
    logic [31:0] last_wr = 32'h0;
    logic        prev_acc = 1'b0;

    always @(negedge clk) begin
        if (spr_access_o) acc_total <= acc_total + 1;
        if (spr_access_o && !prev_acc) starts <= starts + 1;
        if (spr_access_o && spr_we_o && spr_bus_ack_i) begin
            wr_total <= wr_total + 1;
            last_wr  <= spr_dat_o;
        end
        prev_acc <= spr_access_o;
    end

    // ---------------- transaction driver ----------------
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                         input int stall, output logic [31:0] rd, output logic er, output int lat);
        int guard;
        rd = 32'h0; er = 1'b1; lat = -1;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_dat_i = d;
        guard = 0;
        while (!req_ready_o && guard < 200) begin @(negedge clk); guard++; end
        if (!req_ready_o) begin
            n_chk++; n_fail++;
            $display("FAIL handshake_timeout op=%0d addr=%h", op, a);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin @(negedge clk); lat++; end
        if (!rsp_valid_o) begin
            n_chk++; n_fail++;
            $display("FAIL response_timeout op=%0d addr=%h", op, a);
            return;
        end
        rd = rsp_dat_o; er = rsp_err_o;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_chk++;
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== rd || rsp_err_o !== er || req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_hold valid=%b dat=%h err=%b ready=%b want 1 %h %b 0",
                         rsp_valid_o, rsp_dat_o, rsp_err_o, req_ready_o, rd, er);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, spr_access_o, spr_we_o} !== 5'b0 ||
            rsp_dat_o !== 32'h0 || spr_addr_o !== 16'h0 || spr_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs rdy=%b vld=%b err=%b acc=%b we=%b rdat=%h addr=%h wdat=%h want all 0",
                     req_ready_o, rsp_valid_o, rsp_err_o, spr_access_o, spr_we_o, rsp_dat_o, spr_addr_o, spr_dat_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_write();
        logic [31:0] rd; logic er; int lat, w0, a0;
        ack_dly = 0; w0 = wr_total; a0 = acc_total;
        issue(2'd1, PICMR, 32'h0000_00F0, 0, rd, er, lat);
        n_chk++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            n_fail++; $display("FAIL write_rsp lat=%0d dat=%h err=%b want 2 0 0", lat, rd, er);
        end
        n_chk++;
        if (wr_total - w0 !== 1 || acc_total - a0 !== 1 || picmr !== 32'hF0) begin
            n_fail++; $display("FAIL write_bus writes=%0d acc=%0d picmr=%h want 1 1 f0",
                               wr_total - w0, acc_total - a0, picmr);
        end
        issue(2'd0, PICMR, 32'h0, 0, rd, er, lat);
        n_chk++;
        if (lat !== 2 || rd !== 32'hF0 || er !== 1'b0) begin
            n_fail++; $display("FAIL readback lat=%0d dat=%h err=%b want 2 f0 0", lat, rd, er);
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd; logic er; int lat, w0, a0, s0;
        ack_dly = 0;
        issue(2'd1, PICSR, 32'h30, 0, rd, er, lat);
        w0 = wr_total; a0 = acc_total; s0 = starts;
        issue(2'd3, PICSR, 32'h10, 0, rd, er, lat);
        n_chk++;
        if (lat !== 3 || rd !== 32'h30 || er !== 1'b0) begin
            n_fail++; $display("FAIL clrbits_rsp lat=%0d dat=%h err=%b want 3 30 0", lat, rd, er);
        end
        n_chk++;
        if (last_wr !== 32'h20 || picsr !== 32'h20 || acc_total - a0 !== 2 ||
            starts - s0 !== 1 || wr_total - w0 !== 1) begin
            n_fail++; $display("FAIL clrbits_bus wr=%h picsr=%h acc=%0d starts=%0d writes=%0d want 20 20 2 1 1",
                               last_wr, picsr, acc_total - a0, starts - s0, wr_total - w0);
        end
        issue(2'd2, PICMR, 32'h1, 0, rd, er, lat);
        n_chk++;
        if (rd !== 32'hF0 || er !== 1'b0 || last_wr !== 32'hF1 || picmr !== 32'hF1) begin
            n_fail++; $display("FAIL setbits dat=%h err=%b wr=%h picmr=%h want f0 0 f1 f1",
                               rd, er, last_wr, picmr);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int lat, a0, w0;
        ack_dly = 0; a0 = acc_total;
        issue(2'd0, UNMAP, 32'h0, 2, rd, er, lat);
        n_chk++;
        if (acc_total - a0 !== TMO || rd !== 32'h0 || er !== 1'b1 || lat !== TMO + 1) begin
            n_fail++; $display("FAIL timeout_read acc=%0d dat=%h err=%b lat=%0d want %0d 0 1 %0d",
                               acc_total - a0, rd, er, lat, TMO, TMO + 1);
        end
        a0 = acc_total; w0 = wr_total;
        issue(2'd2, UNMAP, 32'hFFFF_FFFF, 0, rd, er, lat);
        n_chk++;
        if (acc_total - a0 !== TMO || wr_total - w0 !== 0 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL timeout_rmw acc=%0d writes=%0d err=%b dat=%h want %0d 0 1 0",
                               acc_total - a0, wr_total - w0, er, rd, TMO);
        end
        // ack in the very cycle the limit is reached still succeeds
        ack_dly = TMO - 1; a0 = acc_total;
        issue(2'd0, PICMR, 32'h0, 0, rd, er, lat);
        n_chk++;
        if (er !== 1'b0 || rd !== 32'hF1 || acc_total - a0 !== TMO) begin
            n_fail++; $display("FAIL ack_at_limit err=%b dat=%h acc=%0d want 0 f1 %0d",
                               er, rd, acc_total - a0, TMO);
        end
        ack_dly = TMO; a0 = acc_total;
        issue(2'd0, PICMR, 32'h0, 0, rd, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'h0 || acc_total - a0 !== TMO) begin
            n_fail++; $display("FAIL ack_past_limit err=%b dat=%h acc=%0d want 1 0 %0d",
                               er, rd, acc_total - a0, TMO);
        end
        ack_dly = 0;
    endtask

    task automatic test_busy();
        int bad;
        ack_dly = 0;
        @(negedge clk);
        cpu_spr_busy_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_addr_i = PICSR; req_dat_i = 32'h0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (req_ready_o !== 1'b0 || spr_access_o !== 1'b0) bad++;
            @(negedge clk);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL busy_blocks bad_cycles=%0d want 0", bad);
        end
        cpu_spr_busy_i = 1'b0;
        #1;
        n_chk++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL busy_release ready=%b want 1", req_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        cpu_spr_busy_i = 1'b1;   // ignored once the access has started
        n_chk++;
        if (spr_access_o !== 1'b1 || spr_addr_o !== PICSR) begin
            n_fail++; $display("FAIL access_after_busy acc=%b addr=%h want 1 %h", spr_access_o, spr_addr_o, PICSR);
        end
        @(negedge clk);
        n_chk++;
        if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h20 || req_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL busy_rsp vld=%b dat=%h ready=%b want 1 20 0", rsp_valid_o, rsp_dat_o, req_ready_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        cpu_spr_busy_i = 1'b0;
    endtask

    task automatic test_reset_mid_rmw();
        int guard, w0, seen;
        logic [31:0] mr0;
        ack_dly = 2; mr0 = picmr;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = 2'd2; req_addr_i = PICMR; req_dat_i = 32'h0F00;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        guard = 0;
        while (!(spr_access_o && !spr_we_o && spr_bus_ack_i) && guard < 20) begin @(negedge clk); guard++; end
        n_chk++;
        if (guard >= 20) begin
            n_fail++; $display("FAIL rmw_rd_ack_not_seen waited=%0d", guard);
        end
        w0 = wr_total;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, spr_access_o, spr_we_o} !== 5'b0 ||
            rsp_dat_o !== 32'h0 || spr_addr_o !== 16'h0 || spr_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_rmw rdy=%b vld=%b err=%b acc=%b we=%b want all 0",
                               req_ready_o, rsp_valid_o, rsp_err_o, spr_access_o, spr_we_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid_o || spr_access_o) seen++;
        end
        n_chk++;
        if (seen !== 0 || wr_total !== w0 || picmr !== mr0) begin
            n_fail++; $display("FAIL after_reset_abort activity=%0d writes=%0d picmr=%h want 0 0 %h",
                               seen, wr_total - w0, picmr, mr0);
        end
        ack_dly = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_mr, exp_sr, old, exp_rd, rd;
        logic [15:0] a;
        logic [1:0]  op;
        logic [31:0] d;
        logic        exp_er, er, hit;
        int          lat, exp_lat, dly, w0, exp_w, bad;
        exp_mr = picmr; exp_sr = picsr; bad = 0;
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0: a = UNMAP;
                1, 2, 3: a = PICMR;
                default: a = PICSR;
            endcase
            d   = $urandom();
            dly = $urandom_range(0, 4);
            ack_dly = dly;
            hit = (a != UNMAP);
            old = (a == PICMR) ? exp_mr : exp_sr;
            exp_er = !hit;
            exp_rd = (!hit || op == 2'd1) ? 32'h0 : old;
            exp_w  = (hit && op != 2'd0) ? 1 : 0;
            if (!hit) exp_lat = TMO + 1;
            else if (op == 2'd0 || op == 2'd1) exp_lat = 2 + dly;
            else exp_lat = 3 + 2 * dly;
            if (hit) begin
                case (op)
                    2'd1: old = d;
                    2'd2: old = old | d;
                    2'd3: old = old & ~d;
                    default: ;
                endcase
                if (a == PICMR) exp_mr = old; else exp_sr = old;
            end
            w0 = wr_total;
            issue(op, a, d, $urandom_range(0, 2), rd, er, lat);
            n_chk++;
            if (rd !== exp_rd || er !== exp_er || lat !== exp_lat || wr_total - w0 !== exp_w ||
                picmr !== exp_mr || picsr !== exp_sr) begin
                n_fail++; bad++;
                $display("FAIL random[%0d] op=%0d addr=%h dat=%h err=%b lat=%0d wr=%0d mr=%h sr=%h want %h %b %0d %0d %h %h",
                         t, op, a, rd, er, lat, wr_total - w0, picmr, picsr,
                         exp_rd, exp_er, exp_lat, exp_w, exp_mr, exp_sr);
            end
            if (bad > 5) break;
        end
        ack_dly = 0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_op_i = 2'd0; req_addr_i = 16'h0; req_dat_i = 32'h0;
        rsp_ready_i = 1'b0; cpu_spr_busy_i = 1'b0;
        test_reset();
        test_write();
        test_rmw();
        test_timeout();
        test_busy();
        test_reset_mid_rmw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
